// File: rtl/riscv_decode_stage_pkg.sv
// Shared RV decode types: instruction views, one-hot instruction set and decoded entry.
// The decoded entry is always RV_XLEN wide; the stage top narrows it to its own XLEN.
package riscv_decode_stage_pkg;

    localparam int RV_XLEN = 64;

    typedef logic [RV_XLEN-1:0] xlen_t;
    typedef logic [4:0]         rv_reg_idx_t;

    typedef struct packed {
        logic [6:0]  funct7;
        rv_reg_idx_t rs2;
        rv_reg_idx_t rs1;
        logic [2:0]  funct3;
        rv_reg_idx_t rd;
        logic [6:0]  opcode;
    } rv_inst_type_t;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Bit position of each instruction in the one-hot set vector.
    typedef enum logic [5:0] {
        RV_LUI, RV_AUIPC, RV_JAL, RV_JALR,
        RV_BEQ, RV_BNE, RV_BLT, RV_BGE, RV_BLTU, RV_BGEU,
        RV_LB, RV_LH, RV_LW, RV_LBU, RV_LHU,
        RV_SB, RV_SH, RV_SW,
        RV_ADDI, RV_SLTI, RV_SLTIU, RV_XORI, RV_ORI, RV_ANDI, RV_SLLI, RV_SRLI, RV_SRAI,
        RV_ADD, RV_SUB, RV_SLL, RV_SLT, RV_SLTU, RV_XOR, RV_SRL, RV_SRA, RV_OR, RV_AND,
        RV_FENCE, RV_ECALL, RV_EBREAK
    } rv_instr_idx_e;

    localparam int NUM_INSTR = 40;
    typedef logic [NUM_INSTR-1:0] rv_instr_set_t;

    // IMM_SHAMT covers the immediate shifts: shamt zero-extended.
    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE, IMM_SHAMT} imm_fmt_t;

    typedef struct packed {
        rv_instr_set_t set;
        rv_reg_idx_t   rd;
        rv_reg_idx_t   rs1;
        rv_reg_idx_t   rs2;
        xlen_t         imm;
        xlen_t         pc;
        logic          illegal;
    } decoded_instr_t;

    function automatic rv_instr_set_t instr_onehot(input rv_instr_idx_e idx);
        return rv_instr_set_t'(1) << idx;
    endfunction

endpackage

// File: rtl/riscv_decode_stage_comb.sv
// Pure combinational RV instruction decoder: raw word + PC in, decoded entry out.
module riscv_decode_comb
    import riscv_decode_stage_pkg::*;
(
    input  logic [31:0]    instr_i,
    input  xlen_t          pc_i,
    output decoded_instr_t dec_o
);

    rv_inst_type_t ins;
    rv_instr_idx_e idx;
    imm_fmt_t      fmt;
    logic          legal;
    xlen_t         imm;

    assign ins = instr_i;

    always_comb begin
        legal = 1'b0;
        idx   = RV_LUI;
        fmt   = IMM_NONE;
        case (ins.opcode)
            OPC_LUI:   begin legal = 1'b1; idx = RV_LUI;   fmt = IMM_U; end
            OPC_AUIPC: begin legal = 1'b1; idx = RV_AUIPC; fmt = IMM_U; end
            OPC_JAL:   begin legal = 1'b1; idx = RV_JAL;   fmt = IMM_J; end
            OPC_JALR: begin
                legal = (ins.funct3 == 3'b000);
                idx   = RV_JALR;
                fmt   = IMM_I;
            end
            OPC_BRANCH: begin
                legal = 1'b1;
                fmt   = IMM_B;
                case (ins.funct3)
                    3'b000:  idx = RV_BEQ;
                    3'b001:  idx = RV_BNE;
                    3'b100:  idx = RV_BLT;
                    3'b101:  idx = RV_BGE;
                    3'b110:  idx = RV_BLTU;
                    3'b111:  idx = RV_BGEU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_LOAD: begin
                legal = 1'b1;
                fmt   = IMM_I;
                case (ins.funct3)
                    3'b000:  idx = RV_LB;
                    3'b001:  idx = RV_LH;
                    3'b010:  idx = RV_LW;
                    3'b100:  idx = RV_LBU;
                    3'b101:  idx = RV_LHU;
                    default: legal = 1'b0;
                endcase
            end
            OPC_STORE: begin
                legal = 1'b1;
                fmt   = IMM_S;
                case (ins.funct3)
                    3'b000:  idx = RV_SB;
                    3'b001:  idx = RV_SH;
                    3'b010:  idx = RV_SW;
                    default: legal = 1'b0;
                endcase
            end
            OPC_OP_IMM: begin
                legal = 1'b1;
                fmt   = IMM_I;
                case (ins.funct3)
                    3'b000: idx = RV_ADDI;
                    3'b010: idx = RV_SLTI;
                    3'b011: idx = RV_SLTIU;
                    3'b100: idx = RV_XORI;
                    3'b110: idx = RV_ORI;
                    3'b111: idx = RV_ANDI;
                    3'b001: begin
                        idx   = RV_SLLI;
                        fmt   = IMM_SHAMT;
                        legal = (instr_i[31:26] == 6'b000000);
                    end
                    default: begin
                        fmt   = IMM_SHAMT;
                        idx   = (instr_i[30]) ? RV_SRAI : RV_SRLI;
                        legal = (instr_i[31:26] == 6'b000000) || (instr_i[31:26] == 6'b010000);
                    end
                endcase
            end
            OPC_OP: begin
                if (ins.funct7 == 7'b0000000) begin
                    legal = 1'b1;
                    case (ins.funct3)
                        3'b000:  idx = RV_ADD;
                        3'b001:  idx = RV_SLL;
                        3'b010:  idx = RV_SLT;
                        3'b011:  idx = RV_SLTU;
                        3'b100:  idx = RV_XOR;
                        3'b101:  idx = RV_SRL;
                        3'b110:  idx = RV_OR;
                        default: idx = RV_AND;
                    endcase
                end else if (ins.funct7 == 7'b0100000) begin
                    legal = (ins.funct3 == 3'b000) || (ins.funct3 == 3'b101);
                    idx   = (ins.funct3 == 3'b000) ? RV_SUB : RV_SRA;
                end
            end
            OPC_MISC_MEM: begin
                legal = (ins.funct3 == 3'b000);
                idx   = RV_FENCE;
                fmt   = IMM_I;
            end
            OPC_SYSTEM: begin
                if (instr_i[31:7] == 25'd0) begin
                    legal = 1'b1;
                    idx   = RV_ECALL;
                end else if (instr_i[31:7] == {12'h001, 13'b0}) begin
                    legal = 1'b1;
                    idx   = RV_EBREAK;
                end
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        case (fmt)
            IMM_I:     imm = {{(RV_XLEN-12){instr_i[31]}}, instr_i[31:20]};
            IMM_S:     imm = {{(RV_XLEN-12){instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            IMM_B:     imm = {{(RV_XLEN-12){instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U:     imm = {{(RV_XLEN-32){instr_i[31]}}, instr_i[31:12], 12'b0};
            IMM_J:     imm = {{(RV_XLEN-20){instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            IMM_SHAMT: imm = {{(RV_XLEN-6){1'b0}}, instr_i[25:20]};
            default:   imm = '0;
        endcase
    end

    assign dec_o.set     = legal ? instr_onehot(idx) : '0;
    assign dec_o.rd      = ins.rd;
    assign dec_o.rs1     = ins.rs1;
    assign dec_o.rs2     = ins.rs2;
    assign dec_o.imm     = legal ? imm : '0;
    assign dec_o.pc      = pc_i;
    assign dec_o.illegal = ~legal;

endmodule

// File: rtl/riscv_decode_stage.sv
// Decode stage: combinational decode into a 2-entry skid FIFO with registered input ready.
// XLEN may be at most RV_XLEN; entries are stored at full width and narrowed on output.
module riscv_decode_stage
    import riscv_decode_stage_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [XLEN-1:0] in_pc_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output rv_instr_set_t   out_set_o,
    output rv_reg_idx_t     out_rd_o,
    output rv_reg_idx_t     out_rs1_o,
    output rv_reg_idx_t     out_rs2_o,
    output logic [XLEN-1:0] out_imm_o,
    output logic [XLEN-1:0] out_pc_o,
    output logic            out_illegal_o
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    decoded_instr_t dec;
    decoded_instr_t mem_q [DEPTH];
    decoded_instr_t head;
    logic [1:0]     count_q, count_d;
    logic           wr_ptr_q, wr_ptr_d;
    logic           rd_ptr_q, rd_ptr_d;
    logic           in_ready_q, in_ready_d;
    logic           push, pop;

    riscv_decode_comb u_decode (
        .instr_i (in_instr_i),
        .pc_i    (xlen_t'(in_pc_i)),
        .dec_o   (dec)
    );

    // Flush wins over both handshakes, so neither side advances in that cycle.
    assign push = in_valid_i && in_ready_q && !flush_i;
    assign pop  = (count_q != 2'd0) && out_ready_i && !flush_i;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
        in_ready_d = (count_d != FULL);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= 2'd0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= dec;
        end
    end

    assign head          = mem_q[rd_ptr_q];
    assign in_ready_o    = in_ready_q;
    assign out_valid_o   = (count_q != 2'd0);
    assign out_set_o     = head.set;
    assign out_rd_o      = head.rd;
    assign out_rs1_o     = head.rs1;
    assign out_rs2_o     = head.rs2;
    assign out_imm_o     = head.imm[XLEN-1:0];
    assign out_pc_o      = head.pc[XLEN-1:0];
    assign out_illegal_o = head.illegal;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// Randomised bench for riscv_decode_stage against a mask/match decode table and queue scoreboard.
module tb_riscv_decode_stage;
    import riscv_decode_stage_pkg::*;

    localparam int XLEN = 64;

    logic            clk_i;
    logic            rst_ni;
    logic            flush_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     in_instr_i;
    logic [XLEN-1:0] in_pc_i;
    logic            out_valid_o;
    logic            out_ready_i;
    rv_instr_set_t   out_set_o;
    rv_reg_idx_t     out_rd_o, out_rs1_o, out_rs2_o;
    logic [XLEN-1:0] out_imm_o, out_pc_o;
    logic            out_illegal_o;

    riscv_decode_stage #(.XLEN(XLEN), .DEPTH(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .flush_i       (flush_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .in_instr_i    (in_instr_i),
        .in_pc_i       (in_pc_i),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .out_set_o     (out_set_o),
        .out_rd_o      (out_rd_o),
        .out_rs1_o     (out_rs1_o),
        .out_rs2_o     (out_rs2_o),
        .out_imm_o     (out_imm_o),
        .out_pc_o      (out_pc_o),
        .out_illegal_o (out_illegal_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Decode reference: each instruction is a (mask, match) pair, as in the ISA opcode tables.
    // fmt codes: 0=I 1=S 2=B 3=U 4=J 5=none 6=shamt
    logic [31:0] t_mask  [NUM_INSTR];
    logic [31:0] t_match [NUM_INSTR];
    int          t_fmt   [NUM_INSTR];

    task automatic tadd(input int idx, input logic [31:0] m, input logic [31:0] k, input int f);
        t_mask[idx] = m; t_match[idx] = k; t_fmt[idx] = f;
    endtask

    task automatic build_table();
        tadd(RV_LUI,   32'h0000007f, 32'h00000037, 3);
        tadd(RV_AUIPC, 32'h0000007f, 32'h00000017, 3);
        tadd(RV_JAL,   32'h0000007f, 32'h0000006f, 4);
        tadd(RV_JALR,  32'h0000707f, 32'h00000067, 0);
        tadd(RV_BEQ,   32'h0000707f, 32'h00000063, 2);
        tadd(RV_BNE,   32'h0000707f, 32'h00001063, 2);
        tadd(RV_BLT,   32'h0000707f, 32'h00004063, 2);
        tadd(RV_BGE,   32'h0000707f, 32'h00005063, 2);
        tadd(RV_BLTU,  32'h0000707f, 32'h00006063, 2);
        tadd(RV_BGEU,  32'h0000707f, 32'h00007063, 2);
        tadd(RV_LB,    32'h0000707f, 32'h00000003, 0);
        tadd(RV_LH,    32'h0000707f, 32'h00001003, 0);
        tadd(RV_LW,    32'h0000707f, 32'h00002003, 0);
        tadd(RV_LBU,   32'h0000707f, 32'h00004003, 0);
        tadd(RV_LHU,   32'h0000707f, 32'h00005003, 0);
        tadd(RV_SB,    32'h0000707f, 32'h00000023, 1);
        tadd(RV_SH,    32'h0000707f, 32'h00001023, 1);
        tadd(RV_SW,    32'h0000707f, 32'h00002023, 1);
        tadd(RV_ADDI,  32'h0000707f, 32'h00000013, 0);
        tadd(RV_SLTI,  32'h0000707f, 32'h00002013, 0);
        tadd(RV_SLTIU, 32'h0000707f, 32'h00003013, 0);
        tadd(RV_XORI,  32'h0000707f, 32'h00004013, 0);
        tadd(RV_ORI,   32'h0000707f, 32'h00006013, 0);
        tadd(RV_ANDI,  32'h0000707f, 32'h00007013, 0);
        tadd(RV_SLLI,  32'hfc00707f, 32'h00001013, 6);
        tadd(RV_SRLI,  32'hfc00707f, 32'h00005013, 6);
        tadd(RV_SRAI,  32'hfc00707f, 32'h40005013, 6);
        tadd(RV_ADD,   32'hfe00707f, 32'h00000033, 5);
        tadd(RV_SUB,   32'hfe00707f, 32'h40000033, 5);
        tadd(RV_SLL,   32'hfe00707f, 32'h00001033, 5);
        tadd(RV_SLT,   32'hfe00707f, 32'h00002033, 5);
        tadd(RV_SLTU,  32'hfe00707f, 32'h00003033, 5);
        tadd(RV_XOR,   32'hfe00707f, 32'h00004033, 5);
        tadd(RV_SRL,   32'hfe00707f, 32'h00005033, 5);
        tadd(RV_SRA,   32'hfe00707f, 32'h40005033, 5);
        tadd(RV_OR,    32'hfe00707f, 32'h00006033, 5);
        tadd(RV_AND,   32'hfe00707f, 32'h00007033, 5);
        tadd(RV_FENCE, 32'h0000707f, 32'h0000000f, 0);
        tadd(RV_ECALL, 32'hffffffff, 32'h00000073, 5);
        tadd(RV_EBREAK,32'hffffffff, 32'h00100073, 5);
    endtask

    typedef struct {
        logic [39:0] set;
        logic [4:0]  rd, rs1, rs2;
        logic [63:0] imm, pc;
        logic        ill;
    } exp_t;

    function automatic exp_t model(input logic [31:0] w, input logic [63:0] pc);
        exp_t   e;
        int     hits = 0;
        int     hit  = 0;
        longint s;
        for (int i = 0; i < NUM_INSTR; i++)
            if ((w & t_mask[i]) == t_match[i]) begin hits++; hit = i; end
        e.rd  = 5'((w >> 7) & 32'h1f);
        e.rs1 = 5'((w >> 15) & 32'h1f);
        e.rs2 = 5'((w >> 20) & 32'h1f);
        e.pc  = pc;
        case (t_fmt[hit])
            0: s = longint'($signed(w)) >>> 20;
            1: s = ((longint'($signed(w)) >>> 25) << 5) | longint'((w >> 7) & 32'h1f);
            2: s = (w[31] ? -64'sd4096 : 64'sd0) + longint'(((w >> 7) & 32'h1) << 11)
                   + longint'(((w >> 25) & 32'h3f) << 5) + longint'(((w >> 8) & 32'hf) << 1);
            3: s = longint'($signed(w & 32'hfffff000));
            4: s = (w[31] ? -64'sd1048576 : 64'sd0) + longint'(((w >> 12) & 32'hff) << 12)
                   + longint'(((w >> 20) & 32'h1) << 11) + longint'(((w >> 21) & 32'h3ff) << 1);
            6: s = longint'((w >> 20) & 32'h3f);
            default: s = 0;
        endcase
        if (hits == 1) begin
            e.ill = 1'b0;
            e.set = 40'b1 << hit;
            e.imm = 64'(s);
        end else begin
            e.ill = 1'b1;
            e.set = '0;
            e.imm = '0;
        end
        return e;
    endfunction

    exp_t sb[$];
    bit   m_ready_ok;
    bit   acc;

    // Inputs are stable from posedge+1 until the next posedge; check and predict at the negedge.
    task automatic step();
        bit push, pop;
        @(negedge clk_i);
        check_val("out_valid", out_valid_o, sb.size() > 0);
        check_val("in_ready",  in_ready_o,  m_ready_ok && sb.size() < 2);
        if (sb.size() > 0) begin
            check_val("set",     out_set_o,     sb[0].set);
            check_val("rd",      out_rd_o,      sb[0].rd);
            check_val("rs1",     out_rs1_o,     sb[0].rs1);
            check_val("rs2",     out_rs2_o,     sb[0].rs2);
            check_val("imm",     out_imm_o,     sb[0].imm);
            check_val("pc",      out_pc_o,      sb[0].pc);
            check_val("illegal", out_illegal_o, sb[0].ill);
        end
        push = in_valid_i && m_ready_ok && (sb.size() < 2) && !flush_i;
        pop  = out_ready_i && (sb.size() > 0) && !flush_i;
        acc  = push;
        if (flush_i) sb.delete();
        else begin
            if (pop)  void'(sb.pop_front());
            if (push) sb.push_back(model(in_instr_i, in_pc_i));
        end
        @(posedge clk_i);
        m_ready_ok = rst_ni;
        #1;
    endtask

    task automatic drive(input bit v, input logic [31:0] w);
        in_valid_i = v;
        in_instr_i = w;
        in_pc_i    = {$urandom, $urandom};
    endtask

    function automatic logic [31:0] rand_word();
        int          r = $urandom_range(0, 9);
        int          k = $urandom_range(0, NUM_INSTR - 1);
        logic [31:0] w = $urandom;
        if (r <= 6)      return (w & ~t_mask[k]) | t_match[k];
        else if (r == 7) return (w & 32'hffffff80) | 32'h0000003b;
        else if (r == 8) return w;
        else             return ($urandom_range(0, 1) == 0) ? 32'h00000073 : ((w & 32'h7fffff80) | 32'h73);
    endfunction

    task automatic directed(input string tag, input logic [31:0] w, input rv_instr_idx_e idx,
                            input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [63:0] imm);
        out_ready_i = 1'b1;
        drive(1'b1, w);
        step();
        drive(1'b0, 32'h0);
        check_val({tag, "_valid"}, out_valid_o, 1'b1);
        check_val({tag, "_set"},   out_set_o,   64'(1) << int'(idx));
        check_val({tag, "_rd"},    out_rd_o,    rd);
        check_val({tag, "_rs1"},   out_rs1_o,   rs1);
        check_val({tag, "_rs2"},   out_rs2_o,   rs2);
        check_val({tag, "_imm"},   out_imm_o,   imm);
        check_val({tag, "_ill"},   out_illegal_o, 1'b0);
        step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        build_table();
        rst_ni = 1'b0; flush_i = 1'b0; out_ready_i = 1'b0; m_ready_ok = 1'b0;
        drive(1'b0, 32'h0);
        repeat (2) @(posedge clk_i);
        #1;
        check_val("rst_valid", out_valid_o,   1'b0);
        check_val("rst_ready", in_ready_o,    1'b0);
        check_val("rst_set",   out_set_o,     '0);
        check_val("rst_imm",   out_imm_o,     '0);
        check_val("rst_pc",    out_pc_o,      '0);
        check_val("rst_rd",    out_rd_o,      '0);
        check_val("rst_ill",   out_illegal_o, 1'b0);
        #2 rst_ni = 1'b1;
        step();

        directed("addi", 32'hFFF00093, RV_ADDI, 5'd1,  5'd0, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        directed("lui",  32'h123452B7, RV_LUI,  5'd5,  5'd8, 5'd3,  64'h0000_0000_1234_5000);
        directed("beq",  32'hFE208EE3, RV_BEQ,  5'd29, 5'd1, 5'd2,  64'hFFFF_FFFF_FFFF_FFFC);

        // Backpressure: two accepts fill the buffer, third word is held until space frees.
        out_ready_i = 1'b0;
        drive(1'b1, rand_word()); step();
        drive(1'b1, rand_word()); step();
        drive(1'b1, rand_word()); step();
        check_val("bp_ready_full", in_ready_o, 1'b0);
        out_ready_i = 1'b1;
        while (!acc && n_tests < 100000) step();
        drive(1'b0, 32'h0);
        repeat (4) step();

        // Illegal words still take slots in order.
        drive(1'b1, 32'h0000003B); step();
        drive(1'b1, 32'h00003003); step();
        drive(1'b1, 32'h40001013); step();
        drive(1'b0, 32'h0);
        repeat (3) step();

        // Flush with a full buffer and a concurrent input.
        out_ready_i = 1'b0;
        drive(1'b1, 32'h00100093); step();
        drive(1'b1, 32'h00200113); step();
        flush_i = 1'b1;
        drive(1'b1, 32'h00300193); step();
        flush_i = 1'b0;
        drive(1'b0, 32'h0);
        check_val("flush_valid", out_valid_o, 1'b0);
        out_ready_i = 1'b1;
        repeat (3) step();

        for (int c = 0; c < 1500; c++) begin
            if (!(in_valid_i && !acc)) begin
                if ($urandom_range(0, 3) != 0) drive(1'b1, rand_word());
                else                          drive(1'b0, rand_word());
            end
            out_ready_i = ($urandom_range(0, 2) != 0);
            flush_i     = ($urandom_range(0, 49) == 0);
            step();
        end
        flush_i = 1'b0;

        // Asynchronous reset mid-stream.
        out_ready_i = 1'b0;
        drive(1'b1, 32'h00500293); step();
        drive(1'b1, 32'h00600313); step();
        drive(1'b0, 32'h0);
        #2 rst_ni = 1'b0;
        #1;
        check_val("arst_valid", out_valid_o, 1'b0);
        check_val("arst_ready", in_ready_o,  1'b0);
        sb.delete();
        m_ready_ok = 1'b0;
        @(posedge clk_i);
        #3 rst_ni = 1'b1;
        out_ready_i = 1'b1;
        step();
        drive(1'b1, 32'h00700393); step();
        drive(1'b0, 32'h0);
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
